// File: rtl/hazard_scoreboard.sv
// Decode-stage stall unit: tracks in-flight GPR/EPC writes and MDU busy time; stall is
// combinational from D inputs and registered state, state updates on the rising edge.
module hazard_scoreboard #(
    parameter int NSTAGE   = 2,
    parameter int TW       = 2,
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int EPC_IDX  = 14
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          D_valid,
    input  logic [4:0]    D_A1,
    input  logic [4:0]    D_A2,
    input  logic [TW-1:0] D_Tuse_rs,
    input  logic [TW-1:0] D_Tuse_rt,
    input  logic [4:0]    D_A3,
    input  logic [TW-1:0] D_Tnew,
    input  logic          D_hilo_op,
    input  logic          D_mdu_start,
    input  logic          D_div_start,
    input  logic          D_eret,
    input  logic          D_mtc0_epc,
    input  logic          flush,
    output logic          stall,
    output logic [3:0]    stall_cause,
    output logic          mdu_busy
);

    localparam int MAXC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int CW   = $clog2(MAXC + 1);

    if (NSTAGE < 1 || NSTAGE > 4) begin : g_bad_nstage
        $error("hazard_scoreboard: NSTAGE must be 1..4");
    end
    if (EPC_IDX < 0 || EPC_IDX > 31) begin : g_bad_epc
        $error("hazard_scoreboard: EPC_IDX must be a CP0 register number 0..31");
    end

    typedef struct packed {
        logic          v;
        logic [4:0]    a3;
        logic [TW-1:0] tnew;
        logic          epc;
    } ent_t;

    ent_t          sb_q [NSTAGE];
    ent_t          sb_d [NSTAGE];
    logic [CW-1:0] cnt_q, cnt_d;

    logic          rs_hit, rt_hit, epc_pend, issue;
    logic [TW-1:0] rs_tnew, rt_tnew;

    // Scan oldest to youngest so the youngest match overwrites (shadows) older ones.
    always_comb begin
        rs_hit   = 1'b0;
        rt_hit   = 1'b0;
        rs_tnew  = '0;
        rt_tnew  = '0;
        epc_pend = 1'b0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (sb_q[k].v && sb_q[k].a3 != 5'd0) begin
                if (sb_q[k].a3 == D_A1) begin
                    rs_hit  = 1'b1;
                    rs_tnew = sb_q[k].tnew;
                end
                if (sb_q[k].a3 == D_A2) begin
                    rt_hit  = 1'b1;
                    rt_tnew = sb_q[k].tnew;
                end
            end
            if (sb_q[k].v && sb_q[k].epc) begin
                epc_pend = 1'b1;
            end
        end
    end

    assign mdu_busy       = (cnt_q != '0);
    assign stall_cause[0] = D_valid && rs_hit && (D_Tuse_rs < rs_tnew);
    assign stall_cause[1] = D_valid && rt_hit && (D_Tuse_rt < rt_tnew);
    assign stall_cause[2] = D_valid && D_hilo_op && mdu_busy;
    assign stall_cause[3] = D_valid && D_eret && epc_pend;
    assign stall          = |stall_cause;
    assign issue          = D_valid && !stall;

    always_comb begin
        for (int k = 0; k < NSTAGE; k++) begin
            sb_d[k] = '0;
        end
        if (!flush) begin
            if (issue) begin
                sb_d[0].v    = (D_A3 != 5'd0) || D_mtc0_epc;
                sb_d[0].a3   = D_A3;
                sb_d[0].tnew = D_Tnew;
                sb_d[0].epc  = D_mtc0_epc;
            end
            for (int k = 1; k < NSTAGE; k++) begin
                sb_d[k]      = sb_q[k-1];
                sb_d[k].tnew = (sb_q[k-1].tnew == '0) ? '0 : sb_q[k-1].tnew - 1'b1;
            end
        end
    end

    // A flush does not touch the counter: an issued mult/div still completes.
    always_comb begin
        cnt_d = cnt_q;
        if (issue && D_div_start) begin
            cnt_d = CW'(DIV_CYC);
        end else if (issue && D_mdu_start) begin
            cnt_d = CW'(MULT_CYC);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NSTAGE; k++) begin
                sb_q[k] <= '0;
            end
            cnt_q <= '0;
        end else begin
            for (int k = 0; k < NSTAGE; k++) begin
                sb_q[k] <= sb_d[k];
            end
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed hazard scenarios then random traffic,
// all checked against an issue-history model of the pipeline.
module tb_hazard_scoreboard;

    localparam int NS    = 3;
    localparam int MULTC = 5;
    localparam int DIVC  = 10;

    typedef struct {
        logic       v;
        logic [4:0] a1, a2, a3;
        logic [1:0] tur, tut, tn;
        logic       hilo, mdu, dv, eret, epc, fl, rst;
    } stim_t;

    typedef struct {
        int         t;
        logic [4:0] a3;
        int         tnew;
        bit         epc;
    } iss_t;

    logic       clk = 1'b0;
    logic       reset, D_valid, D_hilo_op, D_mdu_start, D_div_start, D_eret, D_mtc0_epc, flush;
    logic [4:0] D_A1, D_A2, D_A3;
    logic [1:0] D_Tuse_rs, D_Tuse_rt, D_Tnew;
    logic       stall, mdu_busy;
    logic [3:0] stall_cause;

    int   n_vec = 0, n_err = 0, n_stall = 0;
    int   cyc = 0, kill_t = -100, mdu_rst = -100, mt = -100, ml = 0;
    bit   chk_en = 0;
    iss_t hist[$];

    always #5 clk = ~clk;

    hazard_scoreboard #(.NSTAGE(NS), .TW(2), .MULT_CYC(MULTC), .DIV_CYC(DIVC), .EPC_IDX(14)) dut (
        .clk(clk), .reset(reset), .D_valid(D_valid), .D_A1(D_A1), .D_A2(D_A2),
        .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt), .D_A3(D_A3), .D_Tnew(D_Tnew),
        .D_hilo_op(D_hilo_op), .D_mdu_start(D_mdu_start), .D_div_start(D_div_start),
        .D_eret(D_eret), .D_mtc0_epc(D_mtc0_epc), .flush(flush),
        .stall(stall), .stall_cause(stall_cause), .mdu_busy(mdu_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h want %0h", tag, cyc, got, want);
        end
    endtask

    function automatic stim_t nop();
        stim_t s;
        s = '{v: 0, a1: 0, a2: 0, a3: 0, tur: 0, tut: 0, tn: 0,
              hilo: 0, mdu: 0, dv: 0, eret: 0, epc: 0, fl: 0, rst: 0};
        return s;
    endfunction

    function automatic stim_t ins(input logic [4:0] a1, a2, input logic [1:0] tur, tut,
                                  input logic [4:0] a3, input logic [1:0] tn);
        stim_t s;
        s = nop();
        s.v = 1; s.a1 = a1; s.a2 = a2; s.tur = tur; s.tut = tut; s.a3 = a3; s.tn = tn;
        return s;
    endfunction

    task automatic run_cycle(input stim_t s);
        int   bt_rs, bt_rt, tn_rs, tn_rt, age, tn;
        bit   e_epc, busy;
        logic [3:0] want;
        @(negedge clk);
        D_valid = s.v; D_A1 = s.a1; D_A2 = s.a2; D_A3 = s.a3;
        D_Tuse_rs = s.tur; D_Tuse_rt = s.tut; D_Tnew = s.tn;
        D_hilo_op = s.hilo; D_mdu_start = s.mdu; D_div_start = s.dv;
        D_eret = s.eret; D_mtc0_epc = s.epc; flush = s.fl; reset = s.rst;
        #1;
        bt_rs = -1; bt_rt = -1; tn_rs = 0; tn_rt = 0; e_epc = 0;
        foreach (hist[i]) begin
            age = cyc - hist[i].t - 1;
            if (hist[i].t > kill_t && age >= 0 && age < NS) begin
                tn = (hist[i].tnew > age) ? hist[i].tnew - age : 0;
                if (hist[i].epc) e_epc = 1;
                if (hist[i].a3 != 0 && hist[i].a3 == s.a1 && hist[i].t > bt_rs) begin
                    bt_rs = hist[i].t; tn_rs = tn;
                end
                if (hist[i].a3 != 0 && hist[i].a3 == s.a2 && hist[i].t > bt_rt) begin
                    bt_rt = hist[i].t; tn_rt = tn;
                end
            end
        end
        busy = (mt > mdu_rst) && (cyc > mt) && (cyc - mt <= ml);
        want[0] = s.v && bt_rs >= 0 && int'(s.tur) < tn_rs;
        want[1] = s.v && bt_rt >= 0 && int'(s.tut) < tn_rt;
        want[2] = s.v && s.hilo && busy;
        want[3] = s.v && s.eret && e_epc;
        if (chk_en) begin
            chk("stall", 32'(stall), 32'(|want));
            chk("stall_cause", 32'(stall_cause), 32'(want));
            chk("mdu_busy", 32'(mdu_busy), 32'(busy));
        end
        if (stall === 1'b1) n_stall++;
        if (s.v && want == 4'b0) begin
            hist.push_back('{t: cyc, a3: s.a3, tnew: int'(s.tn), epc: s.epc});
            if (s.dv) begin
                mt = cyc; ml = DIVC;
            end else if (s.mdu) begin
                mt = cyc; ml = MULTC;
            end
        end
        if (s.fl) kill_t = cyc;
        if (s.rst) begin
            kill_t = cyc; mdu_rst = cyc;
        end
        if (hist.size() > 8) void'(hist.pop_front());
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle(nop());
    endtask

    initial begin
        stim_t s;
        s = nop(); s.rst = 1;
        run_cycle(s);
        run_cycle(s);
        chk_en = 1;
        idle(1);

        // Load-use: one bubble, then a producer with no destination.
        run_cycle(ins(0, 0, 0, 0, 5, 2));
        n_stall = 0;
        run_cycle(ins(5, 0, 1, 0, 6, 1));
        run_cycle(ins(5, 0, 1, 0, 6, 1));
        chk("loaduse_stalls", n_stall, 1);
        idle(3);
        run_cycle(ins(0, 0, 0, 0, 0, 2));
        n_stall = 0;
        run_cycle(ins(0, 0, 1, 0, 6, 1));
        chk("a3_zero_stalls", n_stall, 0);
        idle(3);

        // Youngest match shadows the older producer.
        run_cycle(ins(0, 0, 0, 0, 5, 2));
        run_cycle(ins(0, 0, 0, 0, 5, 0));
        n_stall = 0;
        run_cycle(ins(0, 5, 0, 0, 0, 0));
        chk("youngest_stalls", n_stall, 0);
        idle(3);
        run_cycle(ins(0, 0, 0, 0, 5, 2));
        idle(1);
        n_stall = 0;
        run_cycle(ins(0, 5, 0, 0, 0, 0));
        run_cycle(ins(0, 5, 0, 0, 0, 0));
        chk("older_only_stalls", n_stall, 1);
        idle(3);

        // MDU busy windows, then reset while busy.
        s = ins(0, 0, 0, 0, 0, 0); s.hilo = 1; s.mdu = 1;
        run_cycle(s);
        s = ins(0, 0, 0, 0, 2, 1); s.hilo = 1;
        n_stall = 0;
        for (int i = 0; i < 6; i++) run_cycle(s);
        chk("mult_stalls", n_stall, MULTC);
        s.dv = 1; s.a3 = 0;
        run_cycle(s);
        s.dv = 0; s.a3 = 2;
        n_stall = 0;
        for (int i = 0; i < 11; i++) run_cycle(s);
        chk("div_stalls", n_stall, DIVC);
        s.mdu = 1; s.a3 = 0;
        run_cycle(s);
        s.mdu = 0;
        run_cycle(s);
        run_cycle(s);
        s.rst = 1;
        run_cycle(s);
        s.rst = 0;
        run_cycle(s);
        chk("busy_after_rst", 32'(mdu_busy), 0);
        chk("stall_after_rst", 32'(stall), 0);
        idle(2);

        // EPC write ahead of eret.
        s = ins(0, 0, 0, 0, 0, 0); s.epc = 1;
        run_cycle(s);
        s = ins(0, 0, 0, 0, 0, 0); s.eret = 1;
        n_stall = 0;
        for (int i = 0; i < NS + 1; i++) run_cycle(s);
        chk("eret_stalls", n_stall, NS);
        run_cycle(ins(0, 0, 0, 0, 0, 0));
        n_stall = 0;
        run_cycle(s);
        chk("eret_nonepc_stalls", n_stall, 0);
        idle(3);

        // Flush kills the scoreboard but not the MDU countdown.
        s = ins(0, 0, 0, 0, 0, 0); s.hilo = 1; s.mdu = 1;
        run_cycle(s);
        run_cycle(ins(0, 0, 0, 0, 7, 2));
        s = nop(); s.fl = 1;
        run_cycle(s);
        run_cycle(ins(7, 0, 0, 0, 0, 0));
        chk("flush_stall", 32'(stall), 0);
        chk("flush_busy", 32'(mdu_busy), 1);
        idle(6);

        // Idle D with every hazard condition present.
        s = ins(0, 0, 0, 0, 7, 2); s.epc = 1; s.hilo = 1; s.mdu = 1;
        run_cycle(s);
        s = ins(7, 7, 0, 0, 7, 2); s.v = 0; s.hilo = 1; s.eret = 1; s.mdu = 1;
        run_cycle(s);
        chk("idle_stall", 32'(stall), 0);
        idle(8);

        for (int i = 0; i < 3000; i++) begin
            s = ins(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    2'($urandom), 2'($urandom), 5'($urandom_range(0, 3)), 2'($urandom));
            s.v    = ($urandom_range(0, 3) != 0);
            s.hilo = ($urandom_range(0, 4) == 0);
            s.mdu  = ($urandom_range(0, 9) == 0);
            s.dv   = ($urandom_range(0, 19) == 0);
            s.eret = ($urandom_range(0, 7) == 0);
            s.epc  = ($urandom_range(0, 7) == 0);
            s.fl   = ($urandom_range(0, 19) == 0);
            s.rst  = ($urandom_range(0, 99) == 0);
            run_cycle(s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
